// File: rtl/pulse_gen_pkg.sv
// rtl/pulse_gen_pkg.sv - shared types and reset constants for the pulse generator
// Purpose: channel FSM state encoding and the default (post-reset) configuration.
// Ports: none (package).
package pulse_gen_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_e;

  localparam int DEF_PERIOD = 1;
  localparam int DEF_WIDTH  = 0;

endpackage

// File: rtl/pulse_gen_ch.sv
// rtl/pulse_gen_ch.sv - one independent pulse channel (IDLE/RUN FSM, counter, shadowed config)
// Purpose: generates a registered pulse train of programmable period/width, continuous or oneshot.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cfg_we_i          config write for this channel (already decoded)
//   cfg_period_i      period in clk cycles (0 = invalid)
//   cfg_width_i       high time in clk cycles
//   cfg_oneshot_i     1 = stop after one period
//   start_i, stop_i   start / stop requests (stop wins)
//   out_o             registered pulse output
//   busy_o            channel is in RUN
//   done_o            one-cycle pulse when a oneshot finishes (only with PULSE_GEN_MC_DONE_EN)
module pulse_gen_ch
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we_i,
  input  logic [CNT_W-1:0] cfg_period_i,
  input  logic [CNT_W-1:0] cfg_width_i,
  input  logic             cfg_oneshot_i,
  input  logic             start_i,
  input  logic             stop_i,
  output logic             out_o,
  output logic             busy_o
`ifdef PULSE_GEN_MC_DONE_EN
  ,
  output logic             done_o
`endif
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_q, per_d, wid_q, wid_d;
  logic             one_q, one_d;
  logic [CNT_W-1:0] sh_per_q, sh_per_d, sh_wid_q, sh_wid_d;
  logic             sh_one_q, sh_one_d;
  logic             out_q, out_d;
  logic             wrap;
`ifdef PULSE_GEN_MC_DONE_EN
  logic             done_q, done_d;
`endif

  assign wrap = (cnt_q == per_q - ONE);

  always_comb begin
    sh_per_d = cfg_we_i ? cfg_period_i  : sh_per_q;
    sh_wid_d = cfg_we_i ? cfg_width_i   : sh_wid_q;
    sh_one_d = cfg_we_i ? cfg_oneshot_i : sh_one_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    per_d    = per_q;
    wid_d    = wid_q;
    one_d    = one_q;
`ifdef PULSE_GEN_MC_DONE_EN
    done_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_i && !stop_i && (per_q != '0)) begin
          // Start uses the config that was active this cycle; a write in the
          // same cycle stays in the shadow until the first wrap.
          state_d = RUN;
        end else begin
          // Idle channels follow the shadow immediately.
          per_d = sh_per_d;
          wid_d = sh_wid_d;
          one_d = sh_one_d;
        end
      end
      default: begin
        if (stop_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (wrap) begin
          // Period boundary: the only point a running channel takes new config,
          // so a period in flight is never altered.
          cnt_d = '0;
          per_d = sh_per_d;
          wid_d = sh_wid_d;
          one_d = sh_one_d;
          if (one_q) begin
            state_d = IDLE;
`ifdef PULSE_GEN_MC_DONE_EN
            done_d  = 1'b1;
`endif
          end else if (sh_per_d == '0) begin
            // A zero period reloaded while running is as invalid as at start.
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
    endcase
    out_d = (state_d == RUN) && (cnt_d < wid_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      per_q    <= CNT_W'(DEF_PERIOD);
      wid_q    <= CNT_W'(DEF_WIDTH);
      one_q    <= 1'b0;
      sh_per_q <= CNT_W'(DEF_PERIOD);
      sh_wid_q <= CNT_W'(DEF_WIDTH);
      sh_one_q <= 1'b0;
      out_q    <= 1'b0;
`ifdef PULSE_GEN_MC_DONE_EN
      done_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      wid_q    <= wid_d;
      one_q    <= one_d;
      sh_per_q <= sh_per_d;
      sh_wid_q <= sh_wid_d;
      sh_one_q <= sh_one_d;
      out_q    <= out_d;
`ifdef PULSE_GEN_MC_DONE_EN
      done_q   <= done_d;
`endif
    end
  end

  assign out_o  = out_q;
  assign busy_o = (state_q == RUN);
`ifdef PULSE_GEN_MC_DONE_EN
  assign done_o = done_q;
`endif

endmodule

// File: rtl/pulse_gen_mc.sv
// rtl/pulse_gen_mc.sv - multi-channel pulse generator top (config decode + channel array)
// Purpose: NUM_CH independent pulse channels sharing one config write port.
// Optional feature macro: PULSE_GEN_MC_DONE_EN adds the per-channel done output.
// Ports:
//   clk, rst                              clock, synchronous active-high reset
//   cfg_we, cfg_ch                        config write strobe and target channel
//   cfg_period, cfg_width, cfg_oneshot    config write data
//   start, stop                           per-channel requests
//   out                                   registered pulse outputs
//   busy                                  per-channel RUN indication
//   done                                  oneshot completion pulses (PULSE_GEN_MC_DONE_EN only)
module pulse_gen_mc #(
  parameter  int NUM_CH = 4,
  parameter  int CNT_W  = 16,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_width,
  input  logic              cfg_oneshot,
  input  logic [NUM_CH-1:0] start,
  input  logic [NUM_CH-1:0] stop,
  output logic [NUM_CH-1:0] out,
  output logic [NUM_CH-1:0] busy
`ifdef PULSE_GEN_MC_DONE_EN
  ,
  output logic [NUM_CH-1:0] done
`endif
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    // Exact index match: out-of-range cfg_ch values select no channel.
    logic ch_we;
    assign ch_we = cfg_we && (cfg_ch == CH_W'(g));

    pulse_gen_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .cfg_we_i     (ch_we),
      .cfg_period_i (cfg_period),
      .cfg_width_i  (cfg_width),
      .cfg_oneshot_i(cfg_oneshot),
      .start_i      (start[g]),
      .stop_i       (stop[g]),
      .out_o        (out[g]),
      .busy_o       (busy[g])
`ifdef PULSE_GEN_MC_DONE_EN
      ,
      .done_o       (done[g])
`endif
    );
  end

endmodule

// File: tb/tb_pulse_gen_mc.sv
// tb/tb_pulse_gen_mc.sv - scoreboard bench for pulse_gen_mc (3 channels, 8-bit counters)
module tb_pulse_gen_mc;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_we = 1'b0;
  logic [1:0]       cfg_ch = '0;
  logic [CNT_W-1:0] cfg_period = '0;
  logic [CNT_W-1:0] cfg_width = '0;
  logic             cfg_oneshot = 1'b0;
  logic [2:0]       start = '0;
  logic [2:0]       stop = '0;
  logic [2:0]       out;
  logic [2:0]       busy;
  logic [2:0]       done_w;

  typedef struct packed {
    logic [2:0] o;
    logic [2:0] b;
    logic [2:0] d;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  logic [2:0] ed = '0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pulse_gen_mc #(
    .NUM_CH(NUM_CH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_width  (cfg_width),
    .cfg_oneshot(cfg_oneshot),
    .start      (start),
    .stop       (stop),
    .out        (out),
    .busy       (busy)
`ifdef PULSE_GEN_MC_DONE_EN
    ,
    .done       (done_w)
`endif
  );

`ifndef PULSE_GEN_MC_DONE_EN
  assign done_w = '0;
`endif

  // Monitor: compares every registered output sample against the scoreboard.
  always @(negedge clk) begin : mon
    exp_t  e;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (out !== e.o) begin
        errors++;
        $display("FAIL %s out got %b want %b", n, out, e.o);
      end
      checks++;
      if (busy !== e.b) begin
        errors++;
        $display("FAIL %s busy got %b want %b", n, busy, e.b);
      end
`ifdef PULSE_GEN_MC_DONE_EN
      checks++;
      if (done_w !== e.d) begin
        errors++;
        $display("FAIL %s done got %b want %b", n, done_w, e.d);
      end
`endif
    end
  end

  // Apply current inputs across one rising edge, then record what must appear.
  task automatic tick(input logic [2:0] eo, input logic [2:0] eb, input string nm);
    @(posedge clk);
    exp_q.push_back('{o: eo, b: eb, d: ed});
    name_q.push_back(nm);
    #1;
    start  = '0;
    stop   = '0;
    cfg_we = 1'b0;
    ed     = '0;
  endtask

  task automatic set_cfg(input logic [1:0] ch, input logic [7:0] p, input logic [7:0] w,
                         input logic o);
    cfg_we      = 1'b1;
    cfg_ch      = ch;
    cfg_period  = p;
    cfg_width   = w;
    cfg_oneshot = o;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    // Reset
    rst = 1'b1;
    tick(3'b000, 3'b000, "reset0");
    tick(3'b000, 3'b000, "reset1");
    rst = 1'b0;

    // ch0 period 5 width 2 continuous: 1,1,0,0,0 repeating
    set_cfg(2'd0, 8'd5, 8'd2, 1'b0);
    tick(3'b000, 3'b000, "a_cfg");
    start = 3'b001;
    tick(3'b001, 3'b001, "a_start");
    for (int k = 2; k <= 7; k++) begin
      tick({2'b00, (((k - 1) % 5) < 2)}, 3'b001, "a_run");
    end

    // Mid-period reconfig to 3/1: current period finishes as 5/2
    set_cfg(2'd0, 8'd3, 8'd1, 1'b0);
    tick(3'b000, 3'b001, "c_mid");
    tick(3'b000, 3'b001, "c_tail3");
    tick(3'b000, 3'b001, "c_tail4");
    tick(3'b001, 3'b001, "c_new0");
    tick(3'b000, 3'b001, "c_new1");
    tick(3'b000, 3'b001, "c_new2");
    tick(3'b001, 3'b001, "c_new0b");
    tick(3'b000, 3'b001, "c_new1b");
    stop = 3'b001;
    tick(3'b000, 3'b000, "c_stop");
    tick(3'b000, 3'b000, "c_idle");

    // ch1 period 4 width 1 oneshot; second start while running is ignored
    set_cfg(2'd1, 8'd4, 8'd1, 1'b1);
    tick(3'b000, 3'b000, "b_cfg");
    start = 3'b010;
    tick(3'b010, 3'b010, "b_start");
    start = 3'b010;
    tick(3'b000, 3'b010, "b_restart_ign");
    tick(3'b000, 3'b010, "b_cnt2");
    tick(3'b000, 3'b010, "b_cnt3");
    ed = 3'b010;
    tick(3'b000, 3'b000, "b_end");
    tick(3'b000, 3'b000, "b_idle");

    // ch2: start+stop together, width 0, width 7 > period 4
    set_cfg(2'd2, 8'd4, 8'd2, 1'b0);
    tick(3'b000, 3'b000, "d_cfg");
    start = 3'b100;
    stop  = 3'b100;
    tick(3'b000, 3'b000, "d_startstop");
    tick(3'b000, 3'b000, "d_startstop2");
    set_cfg(2'd2, 8'd4, 8'd0, 1'b0);
    tick(3'b000, 3'b000, "d_cfg_w0");
    start = 3'b100;
    tick(3'b000, 3'b100, "d_w0");
    for (int k = 0; k < 4; k++) tick(3'b000, 3'b100, "d_w0_run");
    stop = 3'b100;
    tick(3'b000, 3'b000, "d_w0_stop");
    set_cfg(2'd2, 8'd4, 8'd7, 1'b0);
    tick(3'b000, 3'b000, "d_cfg_w7");
    start = 3'b100;
    tick(3'b100, 3'b100, "d_w7");
    for (int k = 0; k < 5; k++) tick(3'b100, 3'b100, "d_w7_run");
    stop = 3'b100;
    tick(3'b000, 3'b000, "d_w7_stop");

    // period 0 is invalid; out-of-range cfg_ch touches nothing
    set_cfg(2'd0, 8'd0, 8'd1, 1'b0);
    tick(3'b000, 3'b000, "e_cfg_p0");
    start = 3'b001;
    tick(3'b000, 3'b000, "e_per0");
    tick(3'b000, 3'b000, "e_per0b");
    set_cfg(2'd3, 8'd2, 8'd1, 1'b0);
    tick(3'b000, 3'b000, "e_badch");
    start = 3'b111;
    tick(3'b110, 3'b110, "e_all");
    tick(3'b100, 3'b110, "e_all2");

    // Reset mid-run, then defaults period 1 width 0
    rst = 1'b1;
    tick(3'b000, 3'b000, "rst_mid");
    rst = 1'b0;
    start = 3'b111;
    tick(3'b000, 3'b111, "rst_defaults");
    tick(3'b000, 3'b111, "rst_defaults2");
    tick(3'b000, 3'b111, "rst_defaults3");
    stop = 3'b111;
    tick(3'b000, 3'b000, "final_stop");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", exp_q.size());
    end
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_gen_mc.md
PULSE_GEN_MC -- requirements
Module: pulse_gen_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent pulse channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 16, width of period/width counters.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port cfg_we  input  1  config write strobe.
REQ-006 SHALL have port cfg_ch  input  $clog2(NUM_CH) (min 1)  channel index for write.
REQ-007 SHALL have port cfg_period  input  CNT_W  period in clk cycles.
REQ-008 SHALL have port cfg_width  input  CNT_W  high time in clk cycles.
REQ-009 SHALL have port cfg_oneshot  input  1  1 = single pulse then stop, 0 = continuous.
REQ-010 SHALL have port start  input  NUM_CH  per-channel start request.
REQ-011 SHALL have port stop  input  NUM_CH  per-channel stop request.
REQ-012 SHALL have port out  output  NUM_CH  registered pulse outputs.
REQ-013 SHALL have port busy  output  NUM_CH  channel in RUN state.

Function
REQ-014 Each channel SHALL hold FSM states IDLE and RUN plus a CNT_W counter cnt and active config (period, width, oneshot).
REQ-015 In RUN, out SHALL be 1 while cnt < width, else 0; cnt SHALL increment each cycle and wrap to 0 at period-1.
REQ-016 start[i] in IDLE at cycle N SHALL set RUN, cnt=0, with out[i]=1 at cycle N+1 if width>0; busy[i]=1 at N+1.
REQ-017 start[i] while RUN SHALL be ignored (no restart).
REQ-018 stop[i] SHALL force IDLE, out[i]=0, cnt=0 on the next cycle; stop wins over simultaneous start.
REQ-019 Oneshot: on wrap (cnt==period-1) channel SHALL go IDLE instead of restarting.
REQ-020 width==0 SHALL keep out low; width>=period SHALL keep out high for whole RUN.
REQ-021 period==0 SHALL be treated as invalid: start ignored, channel stays IDLE.
REQ-022 cfg_we SHALL write a per-channel shadow; IDLE channels SHALL load it immediately; RUN channels SHALL load it at next wrap (no mid-period glitch).
REQ-023 cfg_ch >= NUM_CH SHALL be ignored.
REQ-024 Channels SHALL be fully independent; simultaneous events on different channels all take effect.

Reset
REQ-025 rst SHALL clear all FSMs to IDLE, cnt=0, out=0, busy=0, shadow/active period=1, width=0, oneshot=0.
REQ-026 rst mid-RUN SHALL drop out to 0 on the next cycle; rst has priority over all inputs.

Configuration
REQ-027 With macro PULSE_GEN_MC_DONE_EN defined, SHALL add output done  NUM_CH: one-cycle pulse at cycle after a oneshot channel returns to IDLE (not on stop); reset value 0.
REQ-028 Without PULSE_GEN_MC_DONE_EN, port done and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-029 Package pulse_gen_pkg SHALL hold the channel state enum (IDLE, RUN) and default constants (DEF_PERIOD=1, DEF_WIDTH=0).
REQ-030 Per-channel logic SHALL be sub-module pulse_gen_ch, instantiated NUM_CH times via generate; top holds config decode only.

Verification
REQ-031 ch0 period=5 width=2 continuous, start at N -> out[0] pattern 1,1,0,0,0 repeating from N+1.
REQ-032 ch1 period=4 width=1 oneshot, start -> single 1-cycle pulse, busy[1] high 4 cycles, done[1] pulse after (DONE_EN).
REQ-033 ch0 running period=5, write period=3 width=1 mid-period -> current period completes as 5/2, then 1,0,0 pattern.
REQ-034 start and stop same cycle on ch2 -> stays IDLE, out[2]=0; width=0 and width=7/period=4 -> constant 0 / constant 1.
REQ-035 rst asserted mid-RUN on all channels -> next cycle out=0, busy=0; start after rst uses period=1 width=0 -> out stays 0.
REQ-036 period=0 written then start -> busy stays 0; cfg_ch=NUM_CH write -> no channel changes.
